regfile_write_arbiter: RTL

- Shares the single write port of the 4x8-bit register file between N_REQ writeback requesters: ALU, load unit and debug/loader.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Keeps a per-register busy scoreboard so decode can stall on RAW/WAW hazards.
- Outputs are registered and drive the register file's write_sel/write_en/write_data directly.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/rr_arbiter.sv | 39 +++
 rtl/regfile_write_arbiter.sv | 80 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the register-file writeback path.
// Requester indices match the slot order of the arbiter's request vectors.
package cpu_pkg;
   localparam int REG_SEL_W = 2;
   localparam int NREG      = 4;
   localparam int DATA_W    = 8;

   typedef logic [REG_SEL_W-1:0] reg_sel_t;
   typedef logic [DATA_W-1:0]    reg_data_t;

   typedef enum logic [1:0] {
      REQ_ALU  = 2'd0,
      REQ_LOAD = 2'd1,
      REQ_DBG  = 2'd2
   } req_id_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback requester bus, decode reservation port and register-file write port.
// The master side is the requesters/decode; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
   parameter int N_REQ = 3
);
   import cpu_pkg::*;
   localparam int GNT_W = $clog2(N_REQ);

   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ*REG_SEL_W-1:0] req_sel;
   logic [N_REQ*DATA_W-1:0]    req_data;
   logic [N_REQ-1:0]           req_ready;
   logic                       rsv_valid;
   reg_sel_t                   rsv_sel;
   logic                       rsv_ready;
   logic [NREG-1:0]            busy;
   logic                       rf_write_en;
   reg_sel_t                   rf_write_sel;
   reg_data_t                  rf_write_data;
   logic [GNT_W-1:0]           last_grant;

   modport master (
      output req_valid, req_sel, req_data, rsv_valid, rsv_sel,
      input  req_ready, rsv_ready, busy, rf_write_en, rf_write_sel,
             rf_write_data, last_grant
   );

   modport slave (
      input  req_valid, req_sel, req_data, rsv_valid, rsv_sel,
      output req_ready, rsv_ready, busy, rf_write_en, rf_write_sel,
             rf_write_data, last_grant
   );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from ptr_q with wraparound.
// The pointer moves to the slot after the winner whenever a grant is issued.
module rr_arbiter #(
   parameter  int N = 3,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   output logic [N-1:0] grant_o,
   output logic [W-1:0] idx_o
);
   logic [W-1:0] ptr_q;
   logic [W-1:0] cand;
   logic         found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = '0;
      for (int off = 0; off < N; off++) begin
         cand = W'((int'(ptr_q) + off) % N);
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (found) begin
         ptr_q <= (int'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback requesters and
// tracks per-register pending writes so decode can stall on hazards.
module regfile_write_arbiter
   import cpu_pkg::*;
#(
   parameter int N_REQ = 3
) (
   input logic                  clk,
   input logic                  rst_n,
   regfile_write_arbiter_if.slave bus
);
   localparam int GNT_W = $clog2(N_REQ);

   reg_sel_t         sel_arr  [N_REQ];
   reg_data_t        data_arr [N_REQ];
   logic [N_REQ-1:0] req_vec;
   logic [N_REQ-1:0] grant;
   logic [GNT_W-1:0] gnt_idx;
   logic             accept;
   reg_sel_t         win_sel;

   logic [NREG-1:0]  busy_q, busy_d;
   logic             we_q;
   reg_sel_t         sel_q;
   reg_data_t        data_q;
   logic [GNT_W-1:0] lg_q;

   genvar gi;
   for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign sel_arr[gi]  = bus.req_sel[gi*REG_SEL_W +: REG_SEL_W];
      assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
   end

   // Masking requests during reset keeps every ready low without extra gating.
   assign req_vec = bus.req_valid & {N_REQ{rst_n}};

   rr_arbiter #(.N(N_REQ)) u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   (req_vec),
      .grant_o (grant),
      .idx_o   (gnt_idx)
   );

   assign accept        = |grant;
   assign win_sel       = sel_arr[gnt_idx];
   assign bus.req_ready = grant;
   assign bus.rsv_ready = rst_n & ~busy_q[bus.rsv_sel];

   // Set is applied after clear so a same-register reservation wins.
   always_comb begin
      busy_d = busy_q;
      if (accept) busy_d[win_sel] = 1'b0;
      if (bus.rsv_valid && bus.rsv_ready) busy_d[bus.rsv_sel] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         we_q   <= 1'b0;
         sel_q  <= '0;
         data_q <= '0;
         lg_q   <= '0;
      end else begin
         busy_q <= busy_d;
         we_q   <= accept;
         if (accept) begin
            sel_q  <= win_sel;
            data_q <= data_arr[gnt_idx];
            lg_q   <= gnt_idx;
         end
      end
   end

   assign bus.busy          = busy_q;
   assign bus.rf_write_en   = we_q;
   assign bus.rf_write_sel  = sel_q;
   assign bus.rf_write_data = data_q;
   assign bus.last_grant    = lg_q;
endmodule
